// File: rtl/bram_dma_pkg.sv
// Shared types for the block-RAM move engine: op codes, FSM states and counter sizing.
// Widths here are the board defaults; the modules take DATA/ADDR as parameters.
package bram_dma_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 13;

   // The word counter needs one bit more than an address so len=2**ADDR fits.
   function automatic int cnt_width(input int addr_w);
      return addr_w + 1;
   endfunction

   localparam int CNT_W = cnt_width(ADDR_W);

   typedef enum logic [1:0] {
      OP_FILL = 2'b00,
      OP_COPY = 2'b01,
      OP_SUM  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      FILL_WR   = 3'd1,
      CP_RD     = 3'd2,
      CP_WR     = 3'd3,
      SUM_RD    = 3'd4,
      SUM_DRAIN = 3'd5,
      DONE      = 3'd6
   } state_e;

endpackage

// File: rtl/bram_dma_if.sv
// Command/status bundle plus the BRAM initiator port of the move engine.
// master = the engine itself; slave = register front-end and RAM side.
interface bram_dma_if
   import bram_dma_pkg::*;
#(
   parameter int DATA = DATA_W,
   parameter int ADDR = ADDR_W
) ();

   logic            start;
   logic [1:0]      op;
   logic [ADDR-1:0] src_addr;
   logic [ADDR-1:0] dst_addr;
   logic [ADDR:0]   len;
   logic [DATA-1:0] fill_data;
   logic            abort;
   logic            busy;
   logic            done;
   logic [DATA-1:0] sum;

   logic            m_en;
   logic            m_wr;
   logic [ADDR-1:0] m_addr;
   logic [DATA-1:0] m_din;
   logic [DATA-1:0] m_dout;

   modport master (
      input  start, op, src_addr, dst_addr, len, fill_data, abort, m_dout,
      output busy, done, sum, m_en, m_wr, m_addr, m_din
   );

   modport slave (
      output start, op, src_addr, dst_addr, len, fill_data, abort, m_dout,
      input  busy, done, sum, m_en, m_wr, m_addr, m_din
   );

endinterface

// File: rtl/bram_dma_addr_gen.sv
// Source/destination address counters and remaining-word counter; load wins over step.
// Zero latency on o_last (decoded from the count register); no backpressure.
module bram_dma_addr_gen
   import bram_dma_pkg::*;
#(
   parameter int ADDR = ADDR_W
) (
   input  logic            i_clk,
   input  logic            i_reset_n,
   input  logic            i_load,
   input  logic [ADDR-1:0] i_src,
   input  logic [ADDR-1:0] i_dst,
   input  logic [ADDR:0]   i_len,
   input  logic            i_step_src,
   input  logic            i_step_dst,
   input  logic            i_step_cnt,
   output logic [ADDR-1:0] o_src,
   output logic [ADDR-1:0] o_dst,
   output logic            o_last
);

   localparam int CW = cnt_width(ADDR);
   localparam logic [ADDR-1:0] A_ONE = ADDR'(1);
   localparam logic [CW-1:0]   C_ONE = CW'(1);

   logic [ADDR-1:0] r_src;
   logic [ADDR-1:0] r_dst;
   logic [CW-1:0]   r_rem;

   // Address adds wrap naturally at 2**ADDR.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_src <= '0;
         r_dst <= '0;
         r_rem <= '0;
      end else if (i_load) begin
         r_src <= i_src;
         r_dst <= i_dst;
         r_rem <= i_len;
      end else begin
         if (i_step_src) r_src <= r_src + A_ONE;
         if (i_step_dst) r_dst <= r_dst + A_ONE;
         if (i_step_cnt) r_rem <= r_rem - C_ONE;
      end
   end

   assign o_src  = r_src;
   assign o_dst  = r_dst;
   assign o_last = (r_rem == C_ONE);

endmodule

// File: rtl/bram_dma.sv
// FILL / COPY / SUM engine driving one BRAM port; one word per cycle (COPY two), done N+1 / 2N+1 / N+2.
// No backpressure: the RAM port is always ready; abort drops to IDLE on the next edge.
module bram_dma
   import bram_dma_pkg::*;
#(
   parameter int DATA = DATA_W,
   parameter int ADDR = ADDR_W
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   bram_dma_if.master bus
);

   state_e          r_state;
   state_e          w_next;
   logic [DATA-1:0] r_fill;
   logic [DATA-1:0] r_sum;
   logic            r_rd_q;

   logic            w_load;
   logic            w_step_src;
   logic            w_step_dst;
   logic            w_step_cnt;
   logic [ADDR-1:0] w_src;
   logic [ADDR-1:0] w_dst;
   logic            w_last;

   logic            w_busy;
   logic            w_done;
   logic            w_en;
   logic            w_wr;
   logic [ADDR-1:0] w_addr;
   logic [DATA-1:0] w_din;
   logic            w_acc;

   bram_dma_addr_gen #(.ADDR(ADDR)) u_addr_gen (
      .i_clk      (i_clk),
      .i_reset_n  (i_reset_n),
      .i_load     (w_load),
      .i_src      (bus.src_addr),
      .i_dst      (bus.dst_addr),
      .i_len      (bus.len),
      .i_step_src (w_step_src),
      .i_step_dst (w_step_dst),
      .i_step_cnt (w_step_cnt),
      .o_src      (w_src),
      .o_dst      (w_dst),
      .o_last     (w_last)
   );

   // Read data arrives one cycle after the read, so accumulate on the cycle after SUM_RD.
   assign w_acc = r_rd_q && ((r_state == SUM_RD) || (r_state == SUM_DRAIN));

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= IDLE;
         r_fill  <= '0;
         r_sum   <= '0;
         r_rd_q  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_rd_q  <= (r_state == SUM_RD);
         if (w_load) begin
            r_fill <= bus.fill_data;
            r_sum  <= '0;
         end else if (w_acc) begin
            r_sum <= r_sum + bus.m_dout;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_load     = 1'b0;
      w_step_src = 1'b0;
      w_step_dst = 1'b0;
      w_step_cnt = 1'b0;
      w_busy     = 1'b1;
      w_done     = 1'b0;
      w_en       = 1'b0;
      w_wr       = 1'b0;
      w_addr     = '0;
      w_din      = '0;

      case (r_state)
         IDLE: begin
            w_busy = 1'b0;
            if (bus.start) begin
               w_load = 1'b1;
               if (bus.len == '0) begin
                  w_next = DONE;
               end else begin
                  case (op_e'(bus.op))
                     OP_FILL: w_next = FILL_WR;
                     OP_COPY: w_next = CP_RD;
                     OP_SUM:  w_next = SUM_RD;
                     default: w_next = DONE;
                  endcase
               end
            end
         end
         FILL_WR: begin
            w_en       = 1'b1;
            w_wr       = 1'b1;
            w_addr     = w_dst;
            w_din      = r_fill;
            w_step_dst = 1'b1;
            w_step_cnt = 1'b1;
            w_next     = w_last ? DONE : FILL_WR;
         end
         CP_RD: begin
            w_en       = 1'b1;
            w_addr     = w_src;
            w_step_src = 1'b1;
            w_next     = CP_WR;
         end
         CP_WR: begin
            w_en       = 1'b1;
            w_wr       = 1'b1;
            w_addr     = w_dst;
            w_din      = bus.m_dout;
            w_step_dst = 1'b1;
            w_step_cnt = 1'b1;
            w_next     = w_last ? DONE : CP_RD;
         end
         SUM_RD: begin
            w_en       = 1'b1;
            w_addr     = w_src;
            w_step_src = 1'b1;
            w_step_cnt = 1'b1;
            w_next     = w_last ? SUM_DRAIN : SUM_RD;
         end
         SUM_DRAIN: begin
            w_next = DONE;
         end
         DONE: begin
            w_busy = 1'b0;
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_busy = 1'b0;
            w_next = IDLE;
         end
      endcase

      // The access already on the port this cycle still completes; nothing follows it.
      if (w_busy && bus.abort) begin
         w_next = IDLE;
      end
   end

   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
   assign bus.sum    = r_sum;
   assign bus.m_en   = w_en;
   assign bus.m_wr   = w_wr;
   assign bus.m_addr = w_addr;
   assign bus.m_din  = w_din;

endmodule

// File: tb/tb_bram_dma.sv
// Directed bench for bram_dma against a behavioural single-port RAM with registered read.
module tb_bram_dma;
   import bram_dma_pkg::*;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   bram_dma_if #(.DATA(8), .ADDR(13)) bus ();

   bram_dma #(.DATA(8), .ADDR(13)) dut (
      .i_clk     (clk),
      .i_reset_n (reset_n),
      .bus       (bus)
   );

   // RAM model; the tb write port preloads contents between commands.
   logic [7:0]  mem [0:8191];
   logic        tb_we;
   logic [12:0] tb_a;
   logic [7:0]  tb_d;
   logic [7:0]  rdata;

   always @(posedge clk) begin
      if (tb_we) mem[tb_a] <= tb_d;
      else if (bus.m_en && bus.m_wr) mem[bus.m_addr] <= bus.m_din;
      if (bus.m_en) rdata <= mem[bus.m_addr];
   end
   assign bus.m_dout = rdata;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [12:0] a, input logic [7:0] d);
      @(negedge clk);
      tb_we = 1'b1;
      tb_a  = a;
      tb_d  = d;
      @(negedge clk);
      tb_we = 1'b0;
   endtask

   logic        l_en   [0:15];
   logic        l_wr   [0:15];
   logic        l_busy [0:15];
   logic        l_done [0:15];
   logic [12:0] l_addr [0:15];
   logic [7:0]  l_din  [0:15];
   logic [7:0]  l_sum  [0:15];

   // Start edge is cycle 0; l_*[k] holds the outputs seen during cycle k.
   task automatic run(input logic [1:0] op, input logic [12:0] src, input logic [12:0] dst,
                      input logic [13:0] len, input logic [7:0] fill, input int ncyc,
                      input int abort_k, input int ign_k, input int rst_k);
      @(negedge clk);
      bus.start     = 1'b1;
      bus.op        = op;
      bus.src_addr  = src;
      bus.dst_addr  = dst;
      bus.len       = len;
      bus.fill_data = fill;
      bus.abort     = (abort_k == 0);
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         l_en[k]   = bus.m_en;
         l_wr[k]   = bus.m_wr;
         l_busy[k] = bus.busy;
         l_done[k] = bus.done;
         l_addr[k] = bus.m_addr;
         l_din[k]  = bus.m_din;
         l_sum[k]  = bus.sum;
         if (k == 1) begin
            bus.start = 1'b0;
            bus.abort = 1'b0;
         end
         if (k == ign_k) begin
            bus.start     = 1'b1;
            bus.op        = 2'b10;
            bus.fill_data = ~fill;
         end else if (k == ign_k + 1) begin
            bus.start     = 1'b0;
            bus.op        = op;
            bus.fill_data = fill;
         end
         if (k == abort_k) bus.abort = 1'b1;
         else if (k == abort_k + 1) bus.abort = 1'b0;
         if (k == rst_k) reset_n = 1'b0;
         else if (k == rst_k + 1) reset_n = 1'b1;
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   logic [7:0] cpd [0:2];

   initial begin
      reset_n       = 1'b0;
      bus.start     = 1'b0;
      bus.op        = 2'b00;
      bus.src_addr  = '0;
      bus.dst_addr  = '0;
      bus.len       = '0;
      bus.fill_data = '0;
      bus.abort     = 1'b0;
      tb_we         = 1'b0;
      tb_a          = '0;
      tb_d          = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_en",   bus.m_en, 0);
      check("rst_wr",   bus.m_wr, 0);
      check("rst_addr", bus.m_addr, 0);
      check("rst_din",  bus.m_din, 0);
      check("rst_sum",  bus.sum, 0);
      reset_n = 1'b1;
      @(negedge clk);

      // FILL 4 words of A5 at 0x10; a second start in cycle 2 must be ignored.
      poke(13'h014, 8'h5A);
      run(2'b00, 13'h0, 13'h010, 14'd4, 8'hA5, 7, -1, 2, -1);
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("fill_en%0d", k),   l_en[k], 1);
         check($sformatf("fill_wr%0d", k),   l_wr[k], 1);
         check($sformatf("fill_addr%0d", k), l_addr[k], 32'h10 + k - 1);
         check($sformatf("fill_din%0d", k),  l_din[k], 8'hA5);
         check($sformatf("fill_busy%0d", k), l_busy[k], 1);
         check($sformatf("fill_done%0d", k), l_done[k], 0);
      end
      check("fill_done5", l_done[5], 1);
      check("fill_busy5", l_busy[5], 0);
      check("fill_en5",   l_en[5], 0);
      check("fill_done6", l_done[6], 0);
      check("fill_en6",   l_en[6], 0);
      for (int i = 0; i < 4; i++) check($sformatf("fill_mem%0d", i), mem[13'h010 + i], 8'hA5);
      check("fill_mem14", mem[13'h014], 8'h5A);

      // COPY 3 words 0x100 -> 0x200.
      cpd[0] = 8'h11; cpd[1] = 8'h22; cpd[2] = 8'h33;
      for (int i = 0; i < 3; i++) poke(13'h100 + 13'(i), cpd[i]);
      run(2'b01, 13'h100, 13'h200, 14'd3, 8'h00, 9, -1, -1, -1);
      for (int k = 1; k <= 6; k++) begin
         check($sformatf("cp_en%0d", k), l_en[k], 1);
         check($sformatf("cp_wr%0d", k), l_wr[k], (k % 2 == 0));
         if (k % 2 == 1) begin
            check($sformatf("cp_addr%0d", k), l_addr[k], 32'h100 + (k - 1) / 2);
         end else begin
            check($sformatf("cp_addr%0d", k), l_addr[k], 32'h200 + k / 2 - 1);
            check($sformatf("cp_din%0d", k),  l_din[k], cpd[k / 2 - 1]);
         end
         check($sformatf("cp_done%0d", k), l_done[k], 0);
      end
      check("cp_done7", l_done[7], 1);
      check("cp_en7",   l_en[7], 0);
      check("cp_done8", l_done[8], 0);
      for (int i = 0; i < 3; i++) check($sformatf("cp_mem%0d", i), mem[13'h200 + i], cpd[i]);

      // SUM across the top-of-memory wrap: F0 + 20 + 05 = 0x115 -> 0x15.
      poke(13'h1FFE, 8'hF0);
      poke(13'h1FFF, 8'h20);
      poke(13'h0000, 8'h05);
      run(2'b10, 13'h1FFE, 13'h0, 14'd3, 8'h00, 7, -1, -1, -1);
      check("sum_addr1", l_addr[1], 13'h1FFE);
      check("sum_addr2", l_addr[2], 13'h1FFF);
      check("sum_addr3", l_addr[3], 13'h0000);
      for (int k = 1; k <= 3; k++) begin
         check($sformatf("sum_en%0d", k), l_en[k], 1);
         check($sformatf("sum_wr%0d", k), l_wr[k], 0);
      end
      check("sum_en4",   l_en[4], 0);
      check("sum_busy4", l_busy[4], 1);
      check("sum_done4", l_done[4], 0);
      check("sum_done5", l_done[5], 1);
      check("sum_val5",  l_sum[5], 8'h15);
      check("sum_hold6", l_sum[6], 8'h15);

      // Reserved op, then len=0: immediate done, no RAM access, sum cleared.
      run(2'b11, 13'h0, 13'h050, 14'd5, 8'h77, 3, -1, -1, -1);
      check("rsvd_done1", l_done[1], 1);
      check("rsvd_busy1", l_busy[1], 0);
      check("rsvd_sum1",  l_sum[1], 0);
      for (int k = 1; k <= 3; k++) check($sformatf("rsvd_en%0d", k), l_en[k], 0);
      check("rsvd_done2", l_done[2], 0);
      run(2'b00, 13'h0, 13'h050, 14'd0, 8'h77, 3, -1, -1, -1);
      check("len0_done1", l_done[1], 1);
      check("len0_sum1",  l_sum[1], 0);
      for (int k = 1; k <= 3; k++) check($sformatf("len0_en%0d", k), l_en[k], 0);

      // Abort in cycle 3 of an 8-word FILL at 0x40.
      poke(13'h043, 8'h77);
      run(2'b00, 13'h0, 13'h040, 14'd8, 8'hC3, 6, 3, -1, -1);
      for (int k = 1; k <= 3; k++) check($sformatf("ab_en%0d", k), l_en[k], 1);
      for (int k = 4; k <= 6; k++) begin
         check($sformatf("ab_en%0d", k),   l_en[k], 0);
         check($sformatf("ab_busy%0d", k), l_busy[k], 0);
      end
      for (int k = 1; k <= 6; k++) check($sformatf("ab_done%0d", k), l_done[k], 0);
      for (int i = 0; i < 3; i++) check($sformatf("ab_mem%0d", i), mem[13'h040 + i], 8'hC3);
      check("ab_mem43", mem[13'h043], 8'h77);
      run(2'b00, 13'h0, 13'h043, 14'd1, 8'h99, 3, -1, -1, -1);
      check("ab2_en1",   l_en[1], 1);
      check("ab2_done2", l_done[2], 1);
      check("ab2_mem43", mem[13'h043], 8'h99);

      // Synchronous reset during a COPY.
      poke(13'h120, 8'hAB);
      poke(13'h221, 8'h66);
      run(2'b01, 13'h120, 13'h220, 14'd4, 8'h00, 6, -1, -1, 3);
      check("rs_en3",   l_en[3], 1);
      check("rs_en4",   l_en[4], 0);
      check("rs_wr4",   l_wr[4], 0);
      check("rs_addr4", l_addr[4], 0);
      check("rs_din4",  l_din[4], 0);
      check("rs_busy4", l_busy[4], 0);
      check("rs_done4", l_done[4], 0);
      check("rs_sum4",  l_sum[4], 0);
      check("rs_en5",   l_en[5], 0);
      check("rs_busy6", l_busy[6], 0);
      check("rs_mem220", mem[13'h220], 8'hAB);
      check("rs_mem221", mem[13'h221], 8'h66);

      // start and abort together in IDLE: the command runs.
      run(2'b00, 13'h0, 13'h300, 14'd2, 8'h5E, 4, 0, -1, -1);
      check("sa_en1",   l_en[1], 1);
      check("sa_en2",   l_en[2], 1);
      check("sa_done3", l_done[3], 1);
      check("sa_mem0",  mem[13'h300], 8'h5E);
      check("sa_mem1",  mem[13'h301], 8'h5E);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bram_dma.md
Name: bram_dma

Overview:
- Single-channel memory-move engine that acts as the initiator on one port of the dual-port block RAM; it drives en/wr/addr/din and samples dout.
- Executes FILL, COPY and SUM (8-bit additive checksum) over a contiguous address range while the CPU uses the other port.
- Sits beside the 6809 bus glue on the EP4CE6 board and is commanded from a small register front-end.

Parameters:
- DATA, 8, memory word width
- ADDR, 13, memory address width; the address space is 2**ADDR words

Ports:
- clk  in  1  single clock for all logic and the BRAM port
- reset_n  in  1  synchronous, active-low reset
- start  in  1  command strobe; sampled only in IDLE
- op  in  2  command code: 00 FILL, 01 COPY, 10 SUM, 11 reserved
- src_addr  in  ADDR  first source address (COPY, SUM)
- dst_addr  in  ADDR  first destination address (COPY, FILL)
- len  in  ADDR+1  word count, 0..2**ADDR
- fill_data  in  DATA  value written by FILL
- abort  in  1  cancels the running command
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle completion pulse
- sum  out  DATA  checksum result; valid when done pulses after SUM
- m_en  out  1  BRAM port enable
- m_wr  out  1  BRAM port write enable
- m_addr  out  ADDR  BRAM port address
- m_din  out  DATA  BRAM port write data
- m_dout  in  DATA  BRAM port read data; registered, valid one cycle after a read

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low (reset_n).
- Reset: state IDLE; busy, done, m_en and m_wr are 0; m_addr, m_din and sum are 0. Reset mid-command stops all BRAM activity from the next cycle. Memory contents are not restored.
- States: IDLE, FILL_WR, CP_RD, CP_WR, SUM_RD, SUM_DRAIN, DONE.
- IDLE:
  - When start=1, latch op, addresses, len and fill_data, clear sum, set busy.
  - If len=0 or op=11, go to DONE; otherwise go to the first state for the op.
  - start is ignored while busy=1.
- Cycle numbering: the start edge is cycle 0.
- FILL: one write per cycle in cycles 1..N (m_en=1, m_wr=1, m_addr=dst+i, m_din=fill_data). done pulses in cycle N+1.
- COPY: alternates CP_RD and CP_WR, so each word takes 2 cycles.
  - CP_RD: m_en=1, m_wr=0, m_addr=src+i.
  - CP_WR: m_en=1, m_wr=1, m_addr=dst+i, m_din=m_dout.
  - Copy is always ascending; an overlapping range with dst>src propagates data by design and is not an error.
  - done pulses in cycle 2N+1.
- SUM:
  - Reads are pipelined, one per cycle, in cycles 1..N.
  - sum <= sum + m_dout, modulo 2**DATA, in each cycle after a read.
  - SUM_DRAIN (cycle N+1) accumulates the last word with m_en=0.
  - done pulses in cycle N+2; sum then holds until the next start.
- DONE: done=1 and busy=0 for one cycle, m_en=0, then IDLE. A start in the DONE cycle is ignored.
- Addresses: increment and wrap modulo 2**ADDR. len=2**ADDR covers the full memory exactly once.
- m_en=0 in every cycle outside FILL_WR, CP_RD, CP_WR and SUM_RD. m_wr is 1 only in FILL_WR and CP_WR.
- abort=1 while busy:
  - Next state is IDLE with no done pulse, and m_en=0 from the next cycle.
  - Writes already issued remain; sum is left partial.
  - abort and start asserted together in IDLE: start wins; abort has no effect in IDLE.
- Internal word counter is ADDR+1 bits wide, so len is never truncated.

Decomposition:
- Package bram_dma_pkg holds:
  - the op codes OP_FILL, OP_COPY, OP_SUM and OP_RSVD;
  - the state enumeration;
  - the word-counter width (ADDR+1).
- One sub-module, bram_dma_addr_gen, holds the src and dst address counters and the remaining-word counter, with load and step inputs and a last flag. The FSM and the data path stay in bram_dma.
- Verification uses the existing bram as the memory model.

Test Plan:
- FILL: dst=0x0010, len=4, fill_data=0xA5 -> writes to 0x10..0x13 in cycles 1..4, done in cycle 5, readback gives A5 A5 A5 A5, 0x14 unchanged.
- COPY: preload 0x0100..0x0102 = 11 22 33; src=0x0100, dst=0x0200, len=3 -> 0x200..0x202 = 11 22 33, done in cycle 7, and m_wr alternates 0,1.
- SUM with wrap: preload 0x1FFE, 0x1FFF, 0x0000 = 0xF0, 0x20, 0x05; src=0x1FFE, len=3 -> m_addr sequence 1FFE, 1FFF, 0000, sum=0x15, done in cycle 5.
- len=0 and op=11: each gives done in cycle 1, m_en never asserted, sum=0x00.
- abort in cycle 3 of FILL len=8 at dst=0x40 -> only 0x40..0x42 are written, no done pulse, busy=0 from cycle 4, and a new start then runs normally.
- reset_n=0 mid-COPY -> next cycle all outputs are 0 and the FSM is in IDLE; start is ignored while busy; start and abort together in IDLE -> the command runs.
